// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drains a FIFO one word at a time and serialises each word onto a UART-style
//   line: 1 start bit (0), DWIDTH data bits LSB first, optional even parity
//   bit, 1 stop bit (1). Frames run back-to-back while the FIFO holds data and
//   the line idles high otherwise. Every bit lasts CLKS_PER_BIT clk cycles.
//
//   Optional feature macro: FIFO_UART_TX_PARITY_EN
//     defined   -> PARITY state after DATA, sends XOR of the data bits.
//     undefined -> DATA goes straight to STOP, no parity logic.
//
// Parameters
//   DWIDTH        data word width (must match the FIFO)
//   CLKS_PER_BIT  clk cycles per serial bit, 2..255
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   empty_i       FIFO empty flag
//   data_i        FIFO read data, valid only when read_o=1 and empty_i=0
//   read_o        FIFO pop request (combinational)
//   tx_o          serial line (registered, idle high)
//   busy_o        high while a frame is in progress
//   frame_done_o  one-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic              read_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DWIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_bit_idx;
    logic [DWIDTH-1:0] r_shift;
    logic              r_tx;
    logic              w_tx;
    logic              w_bit_end;
    logic              w_pop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    assign w_bit_end = (r_cnt == LAST_CNT);

    // A pop happens from IDLE, or at the very end of a stop bit so the next
    // frame's start bit follows with no idle gap.
    assign w_pop = !empty_i && ((r_state == S_IDLE) ||
                                ((r_state == S_STOP) && w_bit_end));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!empty_i) w_next = S_START;
            S_START: if (w_bit_end) w_next = S_DATA;
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == LAST_IDX)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: if (w_bit_end) w_next = S_STOP;
`endif
            S_STOP:  if (w_bit_end) w_next = empty_i ? S_IDLE : S_START;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: w_tx = r_parity;
`endif
            default:  w_tx = 1'b1;
        endcase
        read_o       = w_pop;
        busy_o       = (r_state != S_IDLE);
        frame_done_o = (r_state == S_STOP) && w_bit_end;
    end

    // Line register: lags the state by one cycle, which keeps every bit on
    // the wire exactly CLKS_PER_BIT cycles long while returning high at once
    // on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx;
        end
    end

    assign tx_o = r_tx;

    // Baud counter, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift   <= data_i;
            r_cnt     <= '0;
            r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= ^data_i;
`endif
        end else if (r_state != S_IDLE) begin
            r_cnt <= w_bit_end ? '0 : (r_cnt + CW'(1));
            if ((r_state == S_DATA) && w_bit_end) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx. A queue stands in for the FIFO; a frame-level
//   model predicts the line, pop, busy and frame_done waveforms, and an
//   independent mid-bit receiver decodes the captured line back into bytes.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int DW = 8;
    localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = DW + 2 + PB;
    localparam int F     = NBITS * C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          empty_i;
    logic [DW-1:0] data_i;
    logic          read_o;
    logic          tx_o;
    logic          busy_o;
    logic          frame_done_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];
    logic          dec_par[$];
    logic          s_tx, s_read, s_busy, s_done;

    fifo_uart_tx #(.DWIDTH(DW), .CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .empty_i      (empty_i),
        .data_i       (data_i),
        .read_o       (read_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    // One clock cycle: present FIFO flags at the falling edge, sample the
    // DUT just after, and pop the FIFO model on the rising edge.
    task automatic cyc();
        @(negedge clk);
        empty_i = (q.size() == 0);
        #1;
        data_i = (read_o && !empty_i) ? q[0] : '0;
        #1;
        s_tx   = tx_o;
        s_read = read_o;
        s_busy = busy_o;
        s_done = frame_done_o;
        @(posedge clk);
        if (s_read && rst_n && q.size() > 0) popped.push_back(q.pop_front());
    endtask

    // Loads words into the FIFO with the DUT idle and checks the whole
    // transfer cycle by cycle against the frame-level model.
    task automatic run_frames(input logic [DW-1:0] words[$], input string name);
        int n, ncyc;
        int m_tx, m_rd, m_busy, m_done, first_tx, diff, derr;
        logic cap_tx[$], cap_rd[$], cap_busy[$], cap_done[$];
        logic [DW-1:0] dec[$];
        n    = words.size();
        ncyc = n * F + 6;
        q = words;
        popped.delete();
        dec_par.delete();
        for (int c = 0; c < ncyc; c++) begin
            cyc();
            cap_tx.push_back(s_tx);
            cap_rd.push_back(s_read);
            cap_busy.push_back(s_busy);
            cap_done.push_back(s_done);
        end
        m_tx = 0; m_rd = 0; m_busy = 0; m_done = 0; first_tx = -1;
        for (int c = 0; c < ncyc; c++) begin
            logic e_tx, e_rd, e_busy, e_done;
            int t, f, b;
            e_rd   = (c % F == 0) && (c / F < n);
            e_done = (c > 0) && (c % F == 0) && (c / F <= n);
            e_busy = (c >= 1) && (c <= n * F);
            t = c - 2;
            e_tx = 1'b1;
            if (t >= 0 && t < n * F) begin
                f = t / F;
                b = (t % F) / C;
                if (b == 0)                   e_tx = 1'b0;
                else if (b <= DW)             e_tx = words[f][b-1];
                else if (PB == 1 && b == DW+1) e_tx = ^words[f];
                else                          e_tx = 1'b1;
            end
            if (cap_tx[c] !== e_tx) begin
                if (first_tx < 0) first_tx = c;
                m_tx++;
            end
            if (cap_rd[c]   !== e_rd)   m_rd++;
            if (cap_busy[c] !== e_busy) m_busy++;
            if (cap_done[c] !== e_done) m_done++;
        end
        total++;
        if (m_tx !== 0) begin
            bad++;
            $display("FAIL %s tx_o: %0d wrong cycles (first at %0d), required 0", name, m_tx, first_tx);
        end
        total++;
        if (m_rd !== 0) begin
            bad++;
            $display("FAIL %s read_o: %0d wrong cycles, required 0", name, m_rd);
        end
        total++;
        if (m_busy !== 0) begin
            bad++;
            $display("FAIL %s busy_o: %0d wrong cycles, required 0", name, m_busy);
        end
        total++;
        if (m_done !== 0) begin
            bad++;
            $display("FAIL %s frame_done_o: %0d wrong cycles, required 0", name, m_done);
        end
        // Independent receiver: find start edges, sample in the middle of bits.
        derr = 0;
        for (int i = 1; i < ncyc; i++) begin
            if (cap_tx[i-1] === 1'b1 && cap_tx[i] === 1'b0 && i + F <= ncyc) begin
                int mid;
                logic [DW-1:0] v;
                mid = i + C / 2;
                if (cap_tx[mid] !== 1'b0) derr++;
                for (int j = 0; j < DW; j++) v[j] = cap_tx[mid + (j + 1) * C];
                if (PB == 1) begin
                    dec_par.push_back(cap_tx[mid + (DW + 1) * C]);
                    if (cap_tx[mid + (DW + 1) * C] !== ^v) derr++;
                end
                if (cap_tx[mid + (NBITS - 1) * C] !== 1'b1) derr++;
                dec.push_back(v);
                i = i + F - 1;
            end
        end
        diff = (dec.size() == n) ? 0 : 1;
        if (diff == 0) for (int k = 0; k < n; k++) if (dec[k] !== words[k]) diff++;
        total++;
        if (diff + derr !== 0) begin
            bad++;
            $display("FAIL %s decode: %0d bytes decoded, %0d framing errors, required %0d bytes 0 errors", name, dec.size(), derr, n);
        end
        diff = (popped.size() == n) ? 0 : 1;
        if (diff == 0) for (int k = 0; k < n; k++) if (popped[k] !== words[k]) diff++;
        total++;
        if (diff !== 0) begin
            bad++;
            $display("FAIL %s pop order: %0d pops/%0d diffs, required %0d pops in order", name, popped.size(), diff, n);
        end
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL %s fifo drained: %0d words left, required 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        int e_tx, e_rd, e_busy, e_done;
        e_tx = 0; e_rd = 0; e_busy = 0; e_done = 0;
        rst_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (s_tx   !== 1'b1) e_tx++;
            if (s_read !== 1'b0) e_rd++;
            if (s_busy !== 1'b0) e_busy++;
            if (s_done !== 1'b0) e_done++;
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (s_tx   !== 1'b1) e_tx++;
            if (s_read !== 1'b0) e_rd++;
            if (s_busy !== 1'b0) e_busy++;
        end
        total++;
        if (e_tx !== 0)   begin bad++; $display("FAIL reset tx_o: %0d cycles low, required 0", e_tx); end
        total++;
        if (e_rd !== 0)   begin bad++; $display("FAIL reset read_o: %0d cycles high, required 0", e_rd); end
        total++;
        if (e_busy !== 0) begin bad++; $display("FAIL reset busy_o: %0d cycles high, required 0", e_busy); end
        total++;
        if (e_done !== 0) begin bad++; $display("FAIL reset frame_done_o: %0d cycles high, required 0", e_done); end
    endtask

    task automatic test_single();
        run_frames('{8'hA5}, "single_A5");
    endtask

    task automatic test_back_to_back();
        run_frames('{8'h00, 8'hFF, 8'h3C}, "back_to_back");
    endtask

    task automatic test_full_fifo();
        run_frames('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, "full_fifo");
    endtask

    task automatic test_mid_reset();
        q = '{8'h5A, 8'h77};
        popped.delete();
        // Pop at cycle 0, START 1..4, DATA bits of 4 cycles from 5: cycle 18
        // is inside data bit 3.
        for (int c = 0; c < 19; c++) cyc();
        total++;
        if (s_busy !== 1'b1 || popped.size() !== 1) begin
            bad++;
            $display("FAIL mid_reset pre: busy=%0b pops=%0d, required busy=1 pops=1", s_busy, popped.size());
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset async: tx=%0b busy=%0b done=%0b, required tx=1 busy=0 done=0", tx_o, busy_o, frame_done_o);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        run_frames('{8'h77}, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [DW-1:0] w[$];
            int n;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) w.push_back(DW'($urandom));
            run_frames(w, $sformatf("random_%0d", r));
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        run_frames('{8'hA5}, "parity_A5");
        total++;
        if (dec_par.size() !== 1 || dec_par[0] !== 1'b0) begin
            bad++;
            $display("FAIL parity_A5 bit: %0d bits, value %0b, required 0", dec_par.size(), (dec_par.size() > 0) ? dec_par[0] : 1'bx);
        end
        run_frames('{8'h07}, "parity_07");
        total++;
        if (dec_par.size() !== 1 || dec_par[0] !== 1'b1) begin
            bad++;
            $display("FAIL parity_07 bit: %0d bits, value %0b, required 1", dec_par.size(), (dec_par.size() > 0) ? dec_par[0] : 1'bx);
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        empty_i = 1'b1;
        data_i  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_mid_reset();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit, 5-deep FIFO.
- Pops one word at a time through the FIFO read handshake and serialises it onto a single UART-style line: 1 start bit, DWIDTH data bits LSB first, optional parity bit, 1 stop bit.
- Frames are sent back-to-back whenever the FIFO holds data; the line idles high otherwise.

Parameters:
- DWIDTH, 8, data word width; must match the FIFO's DWIDTH.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 2..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- empty_i  input  1  FIFO empty flag (FIFO empty_o).
- data_i  input  DWIDTH  FIFO read data (FIFO data_o); valid only in a cycle where read_o=1 and empty_i=0.
- read_o  output  1  FIFO pop request (FIFO read_i); combinational.
- tx_o  output  1  serial line; registered; idle high.
- busy_o  output  1  high while a frame is in progress (any state other than IDLE).
- frame_done_o  output  1  one-cycle pulse in the final cycle of each stop bit.

Behaviour:
- Reset values (async, on rst_n low): state=IDLE, tx_o=1, busy_o=0, frame_done_o=0, baud counter=0, bit index=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Baud counter: counts 0..CLKS_PER_BIT-1 inside each bit; a bit ends when count==CLKS_PER_BIT-1. Counter width is clog2(CLKS_PER_BIT) with a minimum of 1.
- Pop handshake:
  - read_o = !empty_i && (state==IDLE || (state==STOP && bit ends this cycle)).
  - In that same cycle data_i is latched into the shift register; the FIFO pops on the same edge.
  - read_o is never high while empty_i=1.
  - data_i is sampled only in a read_o cycle, because the FIFO drives 0 otherwise.
- IDLE:
  - tx_o=1.
  - If !empty_i: pop, counter=0, go to START on the next edge.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - tx_o = shift register bit 0.
  - At each bit end: shift right by 1 and increment bit index.
  - After bit index DWIDTH-1 ends: go to PARITY if enabled, else STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - frame_done_o=1 in the last cycle only.
  - At bit end: if !empty_i, pop and go directly to START (zero idle cycles between frames); else go to IDLE.
- tx_o is registered: it changes one cycle after the state/counter transition that selects it. All bit durations on the line are exactly CLKS_PER_BIT cycles.
- Frame length: (DWIDTH+2)*CLKS_PER_BIT cycles; (DWIDTH+3)*CLKS_PER_BIT with parity.
- empty_i rising mid-frame has no effect on the current frame; it is re-examined only in IDLE and at STOP end.
- Reset mid-frame:
  - tx_o returns high immediately (asynchronous) and state returns to IDLE.
  - The partially sent word is lost; it is not re-popped.
  - The first frame after release starts no earlier than the first edge with rst_n high.
- busy_o = (state != IDLE); it stays high continuously across back-to-back frames.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - tx_o = even parity (XOR of all DWIDTH data bits, computed at the pop) for CLKS_PER_BIT cycles.
  - Frame grows by CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state and no parity logic; DATA goes straight to STOP.

Test Plan:
- Reset with FIFO empty, 20 cycles -> tx_o=1, read_o=0, busy_o=0, frame_done_o=0 throughout.
- CLKS_PER_BIT=4, write 0xA5 into FIFO -> read_o high exactly 1 cycle; tx_o sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles (40 cycles total); frame_done_o single pulse in cycle 40; FIFO empty afterwards.
- Write 0x00, 0xFF, 0x3C consecutively -> three frames with no idle cycle between them (120 cycles); busy_o high continuously; 3 frame_done_o pulses; exactly 3 read_o pulses, each coinciding with a STOP end or the initial IDLE.
- Fill FIFO to full (5 words 0x01..0x05) -> 5 frames in order 0x01..0x05; decoded bytes match; FIFO empty_o asserted after the 5th pop.
- Assert rst_n low during DATA bit 3 of 0x5A, FIFO holding a further 0x77 -> tx_o=1 immediately and busy_o=0; after release the next frame carries 0x77; 0x5A is not resent.
- With FIFO_UART_TX_PARITY_EN defined: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; each frame 44 cycles; stop bit follows the parity bit.
